// File: rtl/pipelined_barrel_shifter_pkg.sv
// shifter_pkg: shift mode encoding and fill helper shared by the barrel shifter files
package shifter_pkg;
  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_mode_e;

  // Bit entering the MSB end on a right shift; SRA replicates the sign.
  function automatic logic right_fill(shift_mode_e mode, logic msb);
    return (mode == SHIFT_SRA) ? msb : 1'b0;
  endfunction
endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: valid/ready operand and result streams of the shifter
interface pipelined_barrel_shifter_if import shifter_pkg::*; #(
  parameter int WIDTH = 32
);
  localparam int LOG2W = $clog2(WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LOG2W-1:0] in_amount;
  shift_mode_e      in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  modport slave (
    input  in_valid, in_data, in_amount, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
  modport master (
    output in_valid, in_data, in_amount, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// shift_stage: one combinational 2^K step of the barrel shifter for all four modes
module shift_stage import shifter_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  shift_mode_e      mode_i,
  output logic [WIDTH-1:0] data_o
);
  localparam int S = 1 << K;
  logic             fill;
  logic [WIDTH-1:0] sll, sr, ror;
  assign fill = right_fill(mode_i, data_i[WIDTH-1]);
  assign sll  = {data_i[WIDTH-S-1:0], {S{1'b0}}};
  assign sr   = {{S{fill}}, data_i[WIDTH-1:S]};
  assign ror  = {data_i[S-1:0], data_i[WIDTH-1:S]};
  always_comb data_o = !en_i ? data_i : (mode_i == SHIFT_SLL) ? sll : (mode_i == SHIFT_ROR) ? ror : sr;
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log-structured shifter, one register stage per amount bit,
// with a per-stage ready chain so bubbles collapse under downstream stall.
module pipelined_barrel_shifter import shifter_pkg::*; #(
  parameter int WIDTH = 32
) (
  input logic                         clk,
  input logic                         rst_n,
  pipelined_barrel_shifter_if.slave   sh
);
  localparam int LOG2W = $clog2(WIDTH);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [LOG2W-1:0] amount;
    shift_mode_e      mode;
  } stage_t;
  stage_t           pay_in [LOG2W];
  stage_t           pay_d  [LOG2W];
  stage_t           pay_q  [LOG2W];
  logic [LOG2W-1:0] v_q, v_in;
  logic [LOG2W:0]   r;
  logic             zero_q;
  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    logic [WIDTH-1:0] shifted;
    if (k == 0) begin : g_first
      assign pay_in[k] = '{data: sh.in_data, amount: sh.in_amount, mode: sh.in_mode};
      assign v_in[k]   = sh.in_valid;
    end else begin : g_next
      assign pay_in[k] = pay_q[k-1];
      assign v_in[k]   = v_q[k-1];
    end
    shift_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
      .data_i (pay_in[k].data),
      .en_i   (pay_in[k].amount[k]),
      .mode_i (pay_in[k].mode),
      .data_o (shifted)
    );
    assign pay_d[k] = '{data: shifted, amount: pay_in[k].amount, mode: pay_in[k].mode};
  end
  always_comb begin
    r[LOG2W] = sh.out_ready;
    for (int i = LOG2W - 1; i >= 0; i--) r[i] = !v_q[i] || r[i+1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q    <= '0;
      zero_q <= 1'b0;
      for (int i = 0; i < LOG2W; i++) pay_q[i] <= '0;
    end else begin
      for (int i = 0; i < LOG2W; i++)
        if (r[i]) begin
          v_q[i] <= v_in[i];
          if (v_in[i]) pay_q[i] <= pay_d[i];
        end
      if (r[LOG2W-1] && v_in[LOG2W-1]) zero_q <= (pay_d[LOG2W-1].data == '0);
    end
  assign sh.in_ready  = r[0];
  assign sh.out_valid = v_q[LOG2W-1];
  assign sh.out_data  = pay_q[LOG2W-1].data;
  assign sh.out_zero  = zero_q;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed vectors, backpressure, random traffic and reset
module tb_pipelined_barrel_shifter;
  import shifter_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;
  bit   in_fire, out_fire;
  logic [7:0] exp_q[$];
  pipelined_barrel_shifter_if #(.WIDTH(8)) sh();
  pipelined_barrel_shifter #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .sh(sh));
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic [2:0]  a;
    shift_mode_e m;
    logic [7:0]  e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %0s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] model(logic [7:0] d, logic [2:0] a, shift_mode_e m);
    logic [15:0] dd;
    logic [7:0]  sra;
    dd  = {d, d} >> a;
    sra = d;
    for (int i = 0; i < 7; i++) if (i < a) sra = {d[7], sra[7:1]};
    return (m == SHIFT_SLL) ? d << a : (m == SHIFT_SRL) ? d >> a : (m == SHIFT_SRA) ? sra : dd[7:0];
  endfunction

  task automatic step(input bit iv, input logic [7:0] d, input logic [2:0] a, input shift_mode_e m, input bit ordy);
    logic [7:0] e;
    @(negedge clk);
    sh.in_valid = iv; sh.in_data = d; sh.in_amount = a; sh.in_mode = m; sh.out_ready = ordy;
    #1;
    in_fire  = iv && sh.in_ready;
    out_fire = sh.out_valid && ordy;
    if (out_fire) begin
      if (exp_q.size() == 0) check("sb_unexpected_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("sb_data", sh.out_data, e);
        check("sb_zero", sh.out_zero, e == 8'h00);
      end
    end
    if (in_fire) exp_q.push_back(model(d, a, m));
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 8'h00, 3'd0, SHIFT_SLL, ordy);
  endtask

  vec_t vt[10];
  vec_t bb[4];
  vec_t bp[4];
  int   acc, outs, cyc;

  initial begin
    vt[0] = '{8'h96, 3'd3, SHIFT_SLL, 8'hB0};
    vt[1] = '{8'h96, 3'd3, SHIFT_SRL, 8'h12};
    vt[2] = '{8'h96, 3'd3, SHIFT_SRA, 8'hF2};
    vt[3] = '{8'h56, 3'd3, SHIFT_SRA, 8'h0A};
    vt[4] = '{8'h96, 3'd3, SHIFT_ROR, 8'hD2};
    vt[5] = '{8'h96, 3'd0, SHIFT_ROR, 8'h96};
    vt[6] = '{8'h80, 3'd7, SHIFT_SRA, 8'hFF};
    vt[7] = '{8'h01, 3'd7, SHIFT_ROR, 8'h02};
    vt[8] = '{8'hFF, 3'd0, SHIFT_SLL, 8'hFF};
    vt[9] = '{8'h01, 3'd1, SHIFT_SRL, 8'h00};
    bb[0] = '{8'h01, 3'd7, SHIFT_SLL, 8'h80};
    bb[1] = '{8'h80, 3'd7, SHIFT_SRL, 8'h01};
    bb[2] = '{8'h01, 3'd1, SHIFT_ROR, 8'h80};
    bb[3] = '{8'h01, 3'd1, SHIFT_SRL, 8'h00};
    bp[0] = '{8'h01, 3'd1, SHIFT_SLL, 8'h02};
    bp[1] = '{8'h80, 3'd2, SHIFT_SRL, 8'h20};
    bp[2] = '{8'h80, 3'd1, SHIFT_SRA, 8'hC0};
    bp[3] = '{8'h0F, 3'd4, SHIFT_ROR, 8'hF0};
    sh.in_valid = 1'b0; sh.in_data = '0; sh.in_amount = '0; sh.in_mode = SHIFT_SLL; sh.out_ready = 1'b1;
    #3;
    check("rst_out_valid", sh.out_valid, 0);
    check("rst_out_data", sh.out_data, 0);
    check("rst_out_zero", sh.out_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      step(1'b1, vt[i].d, vt[i].a, vt[i].m, 1'b1);
      check("vec_accept", in_fire, 1);
      idle(1'b1);
      check("vec_lat1_valid", sh.out_valid, 0);
      idle(1'b1);
      check("vec_lat2_valid", sh.out_valid, 0);
      idle(1'b1);
      check("vec_lat3_valid", sh.out_valid, 1);
      check("vec_data", sh.out_data, vt[i].e);
      check("vec_zero", sh.out_zero, vt[i].e == 8'h00);
    end

    for (int i = 0; i < 7; i++) begin
      if (i < 4) step(1'b1, bb[i].d, bb[i].a, bb[i].m, 1'b1);
      else idle(1'b1);
      if (i >= 3) begin
        check("b2b_valid", sh.out_valid, 1);
        check("b2b_data", sh.out_data, bb[i-3].e);
        check("b2b_zero", sh.out_zero, bb[i-3].e == 8'h00);
      end
    end

    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (acc < 4) step(1'b1, bp[acc].d, bp[acc].a, bp[acc].m, 1'b0);
      else idle(1'b0);
      if (in_fire) acc++;
      if (c >= 3) begin
        check("bp_stall_valid", sh.out_valid, 1);
        check("bp_stall_data", sh.out_data, bp[0].e);
        check("bp_in_ready_low", sh.in_ready, 0);
      end
    end
    check("bp_accepts_before_release", acc, 3);
    outs = 0;
    for (int c = 0; c < 10 && outs < 4; c++) begin
      if (acc < 4) step(1'b1, bp[acc].d, bp[acc].a, bp[acc].m, 1'b1);
      else idle(1'b1);
      if (c == 0) check("bp_full_advance_in_ready", sh.in_ready, 1);
      if (in_fire) acc++;
      if (out_fire) begin
        check("bp_order", sh.out_data, bp[outs].e);
        outs++;
      end
    end
    check("bp_results", outs, 4);
    check("bp_queue_empty", exp_q.size(), 0);

    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 40000) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom_range(0, 7)),
           shift_mode_e'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
      if (in_fire) acc++;
      cyc++;
    end
    check("rand_accepted", acc, 10000);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) idle(1'b1);
    check("rand_drained", exp_q.size(), 0);

    for (int i = 0; i < 3; i++) step(1'b1, 8'h10 + 8'(i), 3'd2, SHIFT_SLL, 1'b0);
    sh.in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_valid", sh.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", sh.out_valid, 0);
    check("midrst_out_data", sh.out_data, 0);
    check("midrst_out_zero", sh.out_zero, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h03, 3'd1, SHIFT_SLL, 1'b1);
    check("postrst_accept", in_fire, 1);
    outs = 0;
    for (int c = 0; c < 8; c++) begin
      idle(1'b1);
      if (out_fire) begin
        check("postrst_data", sh.out_data, 8'h06);
        outs++;
      end
    end
    check("postrst_outputs", outs, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
